// File: rtl/softmax_row_max_mask_if.sv
// Row-stream handshake bundle for softmax_row_max_mask: score beats in, masked beats plus row max out.
// The design takes the slave modport; the producer/consumer side takes master.
interface softmax_row_max_mask_if #(
    parameter int DW   = 16,
    parameter int TOUT = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW*TOUT-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW*TOUT-1:0]   out_data;
    logic [DW-1:0]        out_max;
    logic                 out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_max, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_max, out_last
    );
endinterface

// File: rtl/softmax_row_max_mask.sv
// Causal-mask / tail-pad stage ahead of softmax: buffers each FP16 row, finds its max, replays it.
// Optional SOFTMAX_ROW_PINGPONG_EN: two row buffers so filling row r+1 overlaps draining row r.
module softmax_row_max_mask #(
    parameter int DW        = 16,
    parameter int TOUT      = 8,
    parameter int MAX_TOKEN = 128,
    parameter int TW        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TW-1:0]     cfg_token_len,
    input  logic [TW-1:0]     cfg_row_num,
    input  logic [TW-1:0]     cfg_q_base,
    input  logic              cfg_mask_en,
    output logic              busy,
    output logic              done,
    softmax_row_max_mask_if.slave bus
);
    localparam int DEPTH    = MAX_TOKEN / TOUT;
    localparam int AW       = $clog2(DEPTH);
    localparam int BW       = AW + 1;
    localparam int LOG_TOUT = $clog2(TOUT);
    localparam int CW       = TW + 2;
    localparam int TW1      = TW + 1;
`ifdef SOFTMAX_ROW_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam int MW = $clog2(NBUF * DEPTH);
    localparam logic [DW-1:0] NEG_INF = DW'(16'hFC00);

    logic [TW-1:0]      token_len, row_num, q_base, fill_row;
    logic               mask_en;
    logic [BW-1:0]      nb, wr_beat, rd_beat;
    logic [DW-1:0]      run_max, fold_max, elem;
    logic [CW-1:0]      col, limit;
    logic [DW*TOUT-1:0] masked_beat;
    logic [DW*TOUT-1:0] mem [NBUF*DEPTH];
    logic [MW-1:0]      wr_addr;
    logic               wr_en, in_ready_int;
    logic               out_valid_q, out_last_q;
    logic [DW*TOUT-1:0] out_data_q;
    logic [DW-1:0]      out_max_q;

    // FP16 total order: flipping a positive's sign bit and inverting a negative gives an unsigned key.
    function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] ka, kb;
        ka = a[DW-1] ? ~a : {1'b1, a[DW-2:0]};
        kb = b[DW-1] ? ~b : {1'b1, b[DW-2:0]};
        return (kb > ka) ? b : a;
    endfunction

    // Substitute -inf for padded and causally masked lanes, then fold the beat into the row max.
    always_comb begin
        limit       = CW'(q_base) + CW'(fill_row);
        masked_beat = '0;
        fold_max    = run_max;
        col         = '0;
        elem        = '0;
        for (int i = 0; i < TOUT; i++) begin
            col  = CW'(wr_beat) * CW'(TOUT) + CW'(i);
            elem = bus.in_data[i*DW +: DW];
            if (col >= CW'(token_len) || (mask_en && col > limit))
                elem = NEG_INF;
            masked_beat[i*DW +: DW] = elem;
            fold_max = fmax(fold_max, elem);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= masked_beat;
    end

    assign wr_en         = in_ready_int && bus.in_valid;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_last  = out_last_q;

`ifdef SOFTMAX_ROW_PINGPONG_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state;
    logic          wr_sel, rd_sel;
    logic [1:0]    buf_full;
    logic [DW-1:0] buf_max [2];
    logic [TW-1:0] rd_row;

    assign wr_addr      = {wr_sel, wr_beat[AW-1:0]};
    assign in_ready_int = (state == RUN) && !buf_full[wr_sel] && (fill_row != row_num);

    // Writer and reader run independently in RUN; they never touch the same buffer's full flag at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            token_len   <= '0;
            row_num     <= '0;
            q_base      <= '0;
            mask_en     <= 1'b0;
            nb          <= '0;
            fill_row    <= '0;
            rd_row      <= '0;
            wr_beat     <= '0;
            rd_beat     <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            buf_full    <= '0;
            buf_max[0]  <= NEG_INF;
            buf_max[1]  <= NEG_INF;
            run_max     <= NEG_INF;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_max_q   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        token_len <= cfg_token_len;
                        row_num   <= cfg_row_num;
                        q_base    <= cfg_q_base;
                        mask_en   <= cfg_mask_en;
                        nb        <= BW'(({1'b0, cfg_token_len} + TW1'(TOUT - 1)) >> LOG_TOUT);
                        fill_row  <= '0;
                        rd_row    <= '0;
                        wr_beat   <= '0;
                        rd_beat   <= '0;
                        wr_sel    <= 1'b0;
                        rd_sel    <= 1'b0;
                        buf_full  <= '0;
                        run_max   <= NEG_INF;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (wr_en) begin
                        wr_beat <= wr_beat + BW'(1);
                        run_max <= fold_max;
                        if (wr_beat == nb - BW'(1)) begin
                            buf_max[wr_sel]  <= fold_max;
                            buf_full[wr_sel] <= 1'b1;
                            wr_sel           <= ~wr_sel;
                            wr_beat          <= '0;
                            run_max          <= NEG_INF;
                            fill_row         <= fill_row + TW'(1);
                        end
                    end
                    if (out_valid_q && bus.out_ready && out_last_q) begin
                        out_valid_q      <= 1'b0;
                        out_last_q       <= 1'b0;
                        rd_beat          <= '0;
                        buf_full[rd_sel] <= 1'b0;
                        rd_sel           <= ~rd_sel;
                        rd_row           <= rd_row + TW'(1);
                        if (rd_row + TW'(1) == row_num) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else if ((!out_valid_q || bus.out_ready) && buf_full[rd_sel] && rd_beat < nb) begin
                        out_data_q  <= mem[{rd_sel, rd_beat[AW-1:0]}];
                        out_max_q   <= buf_max[rd_sel];
                        out_last_q  <= (rd_beat == nb - BW'(1));
                        out_valid_q <= 1'b1;
                        rd_beat     <= rd_beat + BW'(1);
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
    state_t state;

    assign wr_addr = wr_beat[AW-1:0];

    // Strict alternation: a row is fully buffered before any of it is replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            token_len    <= '0;
            row_num      <= '0;
            q_base       <= '0;
            mask_en      <= 1'b0;
            nb           <= '0;
            fill_row     <= '0;
            wr_beat      <= '0;
            rd_beat      <= '0;
            run_max      <= NEG_INF;
            in_ready_int <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_max_q    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        token_len    <= cfg_token_len;
                        row_num      <= cfg_row_num;
                        q_base       <= cfg_q_base;
                        mask_en      <= cfg_mask_en;
                        nb           <= BW'(({1'b0, cfg_token_len} + TW1'(TOUT - 1)) >> LOG_TOUT);
                        fill_row     <= '0;
                        wr_beat      <= '0;
                        rd_beat      <= '0;
                        run_max      <= NEG_INF;
                        in_ready_int <= 1'b1;
                        busy         <= 1'b1;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        wr_beat <= wr_beat + BW'(1);
                        run_max <= fold_max;
                        if (wr_beat == nb - BW'(1)) begin
                            out_max_q    <= fold_max;
                            run_max      <= NEG_INF;
                            wr_beat      <= '0;
                            rd_beat      <= '0;
                            in_ready_int <= 1'b0;
                            state        <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && bus.out_ready && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        rd_beat     <= '0;
                        fill_row    <= fill_row + TW'(1);
                        if (fill_row + TW'(1) == row_num) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            in_ready_int <= 1'b1;
                            state        <= FILL;
                        end
                    end else if ((!out_valid_q || bus.out_ready) && rd_beat < nb) begin
                        out_data_q  <= mem[rd_beat[AW-1:0]];
                        out_last_q  <= (rd_beat == nb - BW'(1));
                        out_valid_q <= 1'b1;
                        rd_beat     <= rd_beat + BW'(1);
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule
